// File: rtl/rf_multiport.sv
// rf_multiport: multi-ported register file with an issue/writeback scoreboard.
// Register 0 is hard-wired to zero and never pending. Port index order encodes
// age on the writeback side: a higher index is the younger instruction.
// Build option: define RF_WR_BYPASS_EN to forward same-cycle committing
// writeback data (and the matching busy clear) onto the read ports.
module rf_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int RF_DEPTH   = 32,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 4,
  parameter int ISS_PORTS  = 2,
  localparam int AW        = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WR_PORTS-1:0]            wb_vld,
  input  logic [WR_PORTS-1:0]            wb_wen,
  input  logic [WR_PORTS*AW-1:0]         wb_rd,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wb_data,
  input  logic [ISS_PORTS-1:0]           iss_vld,
  input  logic [ISS_PORTS*AW-1:0]        iss_rd,
  input  logic [RD_PORTS*AW-1:0]         rd_idx,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_busy,
  output logic [WR_PORTS-1:0]            wb_commit,
  output logic [RF_DEPTH-1:0]            busy_vec
);

  logic [DATA_WIDTH-1:0] arr_q [RF_DEPTH];
  logic [DATA_WIDTH-1:0] arr_d [RF_DEPTH];
  logic [RF_DEPTH-1:0]   busy_q;
  logic [RF_DEPTH-1:0]   busy_d;
  logic [WR_PORTS-1:0]   wr_req;
  logic [WR_PORTS-1:0]   commit;

  logic [AW-1:0]         wb_rd_a   [WR_PORTS];
  logic [DATA_WIDTH-1:0] wb_data_a [WR_PORTS];
  logic [AW-1:0]         iss_rd_a  [ISS_PORTS];

  for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_wb_unpack
    assign wr_req[gi]    = wb_vld[gi] & wb_wen[gi];
    assign wb_rd_a[gi]   = wb_rd[gi*AW +: AW];
    assign wb_data_a[gi] = wb_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gi = 0; gi < ISS_PORTS; gi++) begin : g_iss_unpack
    assign iss_rd_a[gi] = iss_rd[gi*AW +: AW];
  end

  // A port commits when it writes a nonzero register that no younger port also targets.
  always_comb begin
    commit = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      commit[i] = wr_req[i] && (wb_rd_a[i] != '0);
      for (int j = i + 1; j < WR_PORTS; j++) begin
        if (wr_req[j] && (wb_rd_a[j] == wb_rd_a[i])) begin
          commit[i] = 1'b0;
        end
      end
    end
  end

  assign wb_commit = commit;

  // Next array/scoreboard state: commits write and clear busy, then allocations set busy (younger wins).
  always_comb begin
    for (int r = 0; r < RF_DEPTH; r++) begin
      arr_d[r]  = arr_q[r];
      busy_d[r] = busy_q[r];
      for (int i = 0; i < WR_PORTS; i++) begin
        if (commit[i] && (wb_rd_a[i] == AW'(r))) begin
          arr_d[r]  = wb_data_a[i];
          busy_d[r] = 1'b0;
        end
      end
      for (int s = 0; s < ISS_PORTS; s++) begin
        if (iss_vld[s] && (iss_rd_a[s] == AW'(r))) begin
          busy_d[r] = 1'b1;
        end
      end
    end
    arr_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // State registers; reset clears the whole array and the scoreboard immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RF_DEPTH; r++) begin
        arr_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < RF_DEPTH; r++) begin
        arr_q[r] <= arr_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    logic [AW-1:0]         idx;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rbusy;

    assign idx      = rd_idx[gi*AW +: AW];
    assign in_range = (int'(idx) < RF_DEPTH);

`ifdef RF_WR_BYPASS_EN
    logic                  fwd_hit;
    logic                  iss_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // Find a committing writeback (at most one) and any allocation that targets this read index.
    always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      iss_hit  = 1'b0;
      for (int i = 0; i < WR_PORTS; i++) begin
        if (commit[i] && (wb_rd_a[i] == idx)) begin
          fwd_hit  = 1'b1;
          fwd_data = wb_data_a[i];
        end
      end
      for (int s = 0; s < ISS_PORTS; s++) begin
        if (iss_vld[s] && (iss_rd_a[s] == idx)) begin
          iss_hit = 1'b1;
        end
      end
    end

    // Read mux with forwarding; a same-cycle reallocation keeps the register pending.
    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (in_range) begin
        rdata = fwd_hit ? fwd_data : arr_q[idx];
        rbusy = busy_q[idx] & ~(fwd_hit & ~iss_hit);
      end
    end
`else
    // Read mux returning the pre-edge array contents; out-of-range indices read as zero.
    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (in_range) begin
        rdata = arr_q[idx];
        rbusy = busy_q[idx];
      end
    end
`endif

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign rd_busy[gi]                          = rbusy;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed scenarios plus random traffic for rf_multiport,
// checked against an array/bitmask reference model kept in the bench.
`timescale 1ns/1ps
module tb_rf_multiport;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int WP = 2;
  localparam int RP = 4;
  localparam int IP = 2;
  localparam int AW = 5;
  localparam int S_DEPTH = 24;

  logic clk = 1'b0;
  logic rst_n;

  logic [WP-1:0]    wb_vld, wb_wen, wb_commit;
  logic [WP*AW-1:0] wb_rd;
  logic [WP*DW-1:0] wb_data;
  logic [IP-1:0]    iss_vld;
  logic [IP*AW-1:0] iss_rd;
  logic [RP*AW-1:0] rd_idx;
  logic [RP*DW-1:0] rd_data;
  logic [RP-1:0]    rd_busy;
  logic [DEPTH-1:0] busy_vec;

  logic [WP-1:0]      s_wb_vld, s_wb_wen, s_wb_commit;
  logic [WP*AW-1:0]   s_wb_rd;
  logic [WP*DW-1:0]   s_wb_data;
  logic [IP-1:0]      s_iss_vld;
  logic [IP*AW-1:0]   s_iss_rd;
  logic [RP*AW-1:0]   s_rd_idx;
  logic [RP*DW-1:0]   s_rd_data;
  logic [RP-1:0]      s_rd_busy;
  logic [S_DEPTH-1:0] s_busy_vec;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_arr [DEPTH];
  logic [DEPTH-1:0] m_busy;

  always #10 clk = ~clk;

  rf_multiport dut (
    .clk(clk), .rst_n(rst_n),
    .wb_vld(wb_vld), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .iss_vld(iss_vld), .iss_rd(iss_rd), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_busy(rd_busy), .wb_commit(wb_commit), .busy_vec(busy_vec)
  );

  rf_multiport #(.RF_DEPTH(S_DEPTH)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .wb_vld(s_wb_vld), .wb_wen(s_wb_wen), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
    .iss_vld(s_iss_vld), .iss_rd(s_iss_rd), .rd_idx(s_rd_idx),
    .rd_data(s_rd_data), .rd_busy(s_rd_busy), .wb_commit(s_wb_commit), .busy_vec(s_busy_vec)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_vld = '0; wb_wen = '0; wb_rd = '0; wb_data = '0;
    iss_vld = '0; iss_rd = '0; rd_idx = '0;
  endtask

  task automatic s_idle();
    s_wb_vld = '0; s_wb_wen = '0; s_wb_rd = '0; s_wb_data = '0;
    s_iss_vld = '0; s_iss_rd = '0; s_rd_idx = '0;
  endtask

  task automatic set_wb(input int p, input int r, input logic [DW-1:0] d);
    wb_vld[p] = 1'b1;
    wb_wen[p] = 1'b1;
    wb_rd[p*AW +: AW] = AW'(r);
    wb_data[p*DW +: DW] = d;
  endtask

  task automatic set_iss(input int p, input int r);
    iss_vld[p] = 1'b1;
    iss_rd[p*AW +: AW] = AW'(r);
  endtask

  task automatic set_rd(input int p, input int r);
    rd_idx[p*AW +: AW] = AW'(r);
  endtask

  function automatic logic [AW-1:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < WP; i++) begin
      wb_vld[i] = ($urandom_range(0, 3) != 0);
      wb_wen[i] = ($urandom_range(0, 3) != 0);
      wb_rd[i*AW +: AW] = rnd_idx();
      wb_data[i*DW +: DW] = $urandom;
    end
    for (int s = 0; s < IP; s++) begin
      iss_vld[s] = ($urandom_range(0, 2) == 0);
      iss_rd[s*AW +: AW] = rnd_idx();
    end
    for (int k = 0; k < RP; k++) rd_idx[k*AW +: AW] = rnd_idx();
  endtask

  // Youngest valid writer of each nonzero register claims it; older writers of the same register lose.
  function automatic logic [WP-1:0] exp_commit();
    logic [DEPTH-1:0] claimed;
    logic [WP-1:0] c;
    int r;
    claimed = '0;
    c = '0;
    for (int i = WP - 1; i >= 0; i--) begin
      r = int'(wb_rd[i*AW +: AW]);
      if (wb_vld[i] && wb_wen[i] && r != 0) begin
        if (!claimed[r]) c[i] = 1'b1;
        claimed[r] = 1'b1;
      end
    end
    return c;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < DEPTH; r++) m_arr[r] = '0;
    m_busy = '0;
  endtask

  // Settle combinational outputs, then compare everything against the model.
  task automatic settle(input string tag);
    logic [WP-1:0] ec;
    logic [DW-1:0] ed;
    logic eb;
    int idx;
    logic hit, ih;
    #4;
    ec = exp_commit();
    chk({tag, ":commit"}, 128'(wb_commit), 128'(ec));
    chk({tag, ":busy_vec"}, 128'(busy_vec), 128'(m_busy));
    for (int k = 0; k < RP; k++) begin
      idx = int'(rd_idx[k*AW +: AW]);
      ed = m_arr[idx];
      eb = m_busy[idx];
      hit = 1'b0;
      ih = 1'b0;
`ifdef RF_WR_BYPASS_EN
      for (int i = 0; i < WP; i++)
        if (ec[i] && int'(wb_rd[i*AW +: AW]) == idx) begin hit = 1'b1; ed = wb_data[i*DW +: DW]; end
      for (int s = 0; s < IP; s++)
        if (iss_vld[s] && int'(iss_rd[s*AW +: AW]) == idx) ih = 1'b1;
      if (hit && !ih) eb = 1'b0;
`endif
      chk($sformatf("%s:rd_data%0d", tag, k), 128'(rd_data[k*DW +: DW]), 128'(ed));
      chk($sformatf("%s:rd_busy%0d", tag, k), 128'(rd_busy[k]), 128'(eb));
    end
  endtask

  // Advance one clock and apply the architectural effect of the inputs seen at that edge.
  task automatic tick();
    logic [WP-1:0] ec;
    ec = exp_commit();
    @(posedge clk);
    for (int i = 0; i < WP; i++) begin
      if (ec[i]) begin
        m_arr[wb_rd[i*AW +: AW]] = wb_data[i*DW +: DW];
        m_busy[wb_rd[i*AW +: AW]] = 1'b0;
      end
    end
    for (int s = 0; s < IP; s++)
      if (iss_vld[s] && iss_rd[s*AW +: AW] != '0) m_busy[iss_rd[s*AW +: AW]] = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    s_idle();
    clear_model();
    set_rd(0, 1); set_rd(1, 5); set_rd(2, 9); set_rd(3, 31);
    settle("reset");
    chk("reset:s_busy_vec", 128'(s_busy_vec), 128'(0));
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two ports write r5: younger wins.
    idle();
    set_wb(0, 5, 32'hAAAA); set_wb(1, 5, 32'hBBBB);
    settle("alias");
    chk("alias:commit_lit", 128'(wb_commit), 128'(2'b10));
    tick();
    idle(); set_rd(0, 5);
    settle("alias_rd");
    chk("alias_rd:lit", 128'(rd_data[31:0]), 128'(32'hBBBB));
    tick();

    // Write to r0 is dropped.
    idle();
    set_wb(0, 0, 32'hFFFF_FFFF); set_rd(0, 0);
    settle("r0");
    chk("r0:commit_lit", 128'(wb_commit), 128'(0));
    tick();
    idle(); set_rd(0, 0);
    settle("r0_after");
    chk("r0_after:rd_lit", 128'(rd_data[31:0]), 128'(0));
    chk("r0_after:busy0", 128'(busy_vec[0]), 128'(0));
    tick();

    // Issue r7, write it back three cycles later.
    idle(); set_iss(0, 7);
    settle("sb_c0"); tick();
    idle(); set_rd(0, 7);
    settle("sb_c1");
    chk("sb_c1:busy7", 128'(busy_vec[7]), 128'(1));
    tick();
    settle("sb_c2"); tick();
    idle(); set_wb(0, 7, 32'h1234); set_rd(0, 7);
    settle("sb_c3");
`ifdef RF_WR_BYPASS_EN
    chk("sb_c3:fwd_data", 128'(rd_data[31:0]), 128'(32'h1234));
    chk("sb_c3:fwd_busy", 128'(rd_busy[0]), 128'(0));
`else
    chk("sb_c3:old_data", 128'(rd_data[31:0]), 128'(0));
    chk("sb_c3:old_busy", 128'(rd_busy[0]), 128'(1));
`endif
    tick();
    idle(); set_rd(0, 7);
    settle("sb_c4");
    chk("sb_c4:busy7", 128'(busy_vec[7]), 128'(0));
    chk("sb_c4:data", 128'(rd_data[31:0]), 128'(32'h1234));
    tick();

    // Issue and writeback of r9 together: set wins, data lands.
    idle(); set_iss(0, 9); set_wb(1, 9, 32'h9999);
    settle("setclr"); tick();
    idle(); set_rd(1, 9);
    settle("setclr_after");
    chk("setclr_after:busy9", 128'(busy_vec[9]), 128'(1));
    chk("setclr_after:data", 128'(rd_data[63:32]), 128'(32'h9999));
    tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      randomize_inputs();
      settle($sformatf("rnd%0d", n));
      tick();
    end

    // Fill r1..r31, mark some busy, then pulse reset between edges.
    for (int r = 1; r < DEPTH; r += 2) begin
      idle();
      set_wb(0, r, 32'hC0DE_0000 | 32'(r));
      if (r + 1 < DEPTH) set_wb(1, r + 1, 32'hC0DE_0000 | 32'(r + 1));
      settle($sformatf("fill%0d", r));
      tick();
    end
    idle(); set_iss(0, 3); set_iss(1, 12);
    settle("fill_busy"); tick();
    idle(); set_wb(0, 4, 32'hDEAD);
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    chk("rstpulse:commit_follows", 128'(wb_commit), 128'(2'b01));
    chk("rstpulse:busy_vec", 128'(busy_vec), 128'(0));
    for (int g = 0; g < DEPTH / RP; g++) begin
      for (int k = 0; k < RP; k++) set_rd(k, g * RP + k);
      #1;
      for (int k = 0; k < RP; k++) begin
        chk($sformatf("rstpulse:rd_data%0d", g * RP + k), 128'(rd_data[k*DW +: DW]), 128'(0));
        chk($sformatf("rstpulse:rd_busy%0d", g * RP + k), 128'(rd_busy[k]), 128'(0));
      end
    end
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(); set_rd(0, 4); set_rd(1, 31);
    settle("post_rst");
    chk("post_rst:r4", 128'(rd_data[31:0]), 128'(0));
    tick();

    // Out-of-range reads on the 24-entry instance.
    idle();
    s_wb_vld = 2'b11; s_wb_wen = 2'b11;
    s_wb_rd = {5'd26, 5'd20};
    s_wb_data = {32'h7777, 32'h5A5A};
    s_iss_vld = 2'b11; s_iss_rd = {5'd3, 5'd25};
    s_rd_idx = {5'd20, 5'd31, 5'd26, 5'd24};
    #4;
    chk("oor:commit", 128'(s_wb_commit), 128'(2'b11));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("oor:rd_data%0d", k), 128'(s_rd_data[k*DW +: DW]), 128'(0));
      chk($sformatf("oor:rd_busy%0d", k), 128'(s_rd_busy[k]), 128'(0));
    end
    @(posedge clk);
    #1;
    s_wb_vld = '0; s_wb_wen = '0; s_iss_vld = '0;
    #4;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("oor2:rd_data%0d", k), 128'(s_rd_data[k*DW +: DW]), 128'(0));
      chk($sformatf("oor2:rd_busy%0d", k), 128'(s_rd_busy[k]), 128'(0));
    end
    chk("oor2:r20", 128'(s_rd_data[3*DW +: DW]), 128'(32'h5A5A));
    chk("oor2:busy_vec", 128'(s_busy_vec), 128'(24'h000008));
    s_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
